alu_rr_scheduler: RTL and testbench

//   Shares one combinational 8-bit ALU (2 operands, 3-bit opcode, ena, 16-bit result) between two

---
 rtl/alu_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one combinational ALU between two requesters
module alu_rr_scheduler #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic [2:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   input  logic [2:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_result,
   output logic        rsp_err,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_opcode,
   output logic        alu_ena,
   input  logic [15:0] alu_result,
   output logic        busy
);

   localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   generate
      if (EXEC_CYCLES < 1) begin : g_exec_cycles_check
         $error("EXEC_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          last_grant;
   logic [CW-1:0] counter;
   logic          grant_any;
   logic          grant_id;
   logic [7:0]    sel_a;
   logic [7:0]    sel_b;
   logic [2:0]    sel_op;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      sel_a     = grant_id ? req1_a  : req0_a;
      sel_b     = grant_id ? req1_b  : req0_b;
      sel_op    = grant_id ? req1_op : req0_op;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            if (counter == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign alu_ena   = (state == EXEC);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         counter    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  alu_a      <= sel_a;
                  alu_b      <= sel_b;
                  alu_opcode <= sel_op;
                  rsp_id     <= grant_id;
                  last_grant <= grant_id;
                  counter    <= CW'(EXEC_CYCLES - 1);
               end
            end
            EXEC: begin
               if (counter != '0) begin
                  counter <= counter - CW'(1);
               end else begin
                  rsp_result <= alu_result;
                  rsp_err    <= ((alu_opcode == 3'b011) || (alu_opcode == 3'b100))
                                && (alu_b == 8'd0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;

   logic clk;
   logic reset;

   logic        d1_req0_valid, d1_req0_ready, d1_req1_valid, d1_req1_ready;
   logic [7:0]  d1_req0_a, d1_req0_b, d1_req1_a, d1_req1_b;
   logic [2:0]  d1_req0_op, d1_req1_op;
   logic        d1_rsp_valid, d1_rsp_ready, d1_rsp_id, d1_rsp_err;
   logic [15:0] d1_rsp_result;
   logic [7:0]  d1_alu_a, d1_alu_b;
   logic [2:0]  d1_alu_opcode;
   logic        d1_alu_ena, d1_busy;
   logic [15:0] d1_alu_result;

   logic        d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
   logic [7:0]  d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b;
   logic [2:0]  d3_req0_op, d3_req1_op;
   logic        d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_rsp_err;
   logic [15:0] d3_rsp_result;
   logic [7:0]  d3_alu_a, d3_alu_b;
   logic [2:0]  d3_alu_opcode;
   logic        d3_alu_ena, d3_busy;
   logic [15:0] d3_alu_result;

   int checks = 0;
   int failures = 0;

   // Stand-in for the shared ALU; drives 0 when not enabled so a mistimed sample shows up.
   function automatic logic [15:0] alu_f(input logic ena, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] op);
      logic [15:0] r;
      r = 16'h0000;
      if (ena) begin
         case (op)
            3'b000: r = {8'h00, a} + {8'h00, b};
            3'b001: r = {8'h00, a} - {8'h00, b};
            3'b010: r = {8'h00, a} * {8'h00, b};
            3'b011: r = (b == 8'd0) ? 16'h0000 : {8'h00, a / b};
            3'b100: r = (b == 8'd0) ? 16'h0000 : {8'h00, a % b};
            3'b101: r = {15'd0, a == b};
            3'b110: r = {15'd0, a > b};
            default: r = {15'd0, a < b};
         endcase
      end
      return r;
   endfunction

   assign d1_alu_result = alu_f(d1_alu_ena, d1_alu_a, d1_alu_b, d1_alu_opcode);
   assign d3_alu_result = alu_f(d3_alu_ena, d3_alu_a, d3_alu_b, d3_alu_opcode);

   alu_rr_scheduler #(.EXEC_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(d1_req0_valid), .req0_ready(d1_req0_ready),
      .req0_a(d1_req0_a), .req0_b(d1_req0_b), .req0_op(d1_req0_op),
      .req1_valid(d1_req1_valid), .req1_ready(d1_req1_ready),
      .req1_a(d1_req1_a), .req1_b(d1_req1_b), .req1_op(d1_req1_op),
      .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_id(d1_rsp_id),
      .rsp_result(d1_rsp_result), .rsp_err(d1_rsp_err),
      .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_opcode(d1_alu_opcode),
      .alu_ena(d1_alu_ena), .alu_result(d1_alu_result), .busy(d1_busy)
   );

   alu_rr_scheduler #(.EXEC_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready),
      .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req0_op(d3_req0_op),
      .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready),
      .req1_a(d3_req1_a), .req1_b(d3_req1_b), .req1_op(d3_req1_op),
      .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
      .rsp_result(d3_rsp_result), .rsp_err(d3_rsp_err),
      .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_opcode(d3_alu_opcode),
      .alu_ena(d3_alu_ena), .alu_result(d3_alu_result), .busy(d3_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Waits (bounded) for a dut1 response, checks it, and lets rsp_ready=1 consume it.
   task automatic wait_rsp(input string tag, input logic id, input logic [15:0] res,
                           input logic err);
      int n;
      n = 0;
      while (d1_rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {15'd0, d1_rsp_valid}, 16'd1);
      chk({tag, "_id"}, {15'd0, d1_rsp_id}, {15'd0, id});
      chk({tag, "_result"}, d1_rsp_result, res);
      chk({tag, "_err"}, {15'd0, d1_rsp_err}, {15'd0, err});
      tick();
   endtask

   initial begin
      reset = 1'b1;
      {d1_req0_valid, d1_req1_valid, d1_rsp_ready} = '0;
      {d1_req0_a, d1_req0_b, d1_req0_op, d1_req1_a, d1_req1_b, d1_req1_op} = '0;
      {d3_req0_valid, d3_req1_valid} = '0;
      d3_rsp_ready = 1'b1;
      {d3_req0_a, d3_req0_b, d3_req0_op, d3_req1_a, d3_req1_b, d3_req1_op} = '0;
      do_reset();

      // Reset state
      #1;
      chk("rst_busy", {15'd0, d1_busy}, 16'd0);
      chk("rst_rsp_valid", {15'd0, d1_rsp_valid}, 16'd0);
      chk("rst_alu_ena", {15'd0, d1_alu_ena}, 16'd0);
      chk("rst_alu_a", {8'd0, d1_alu_a}, 16'd0);
      chk("rst_rsp_result", d1_rsp_result, 16'd0);
      chk("rst_ready0", {15'd0, d1_req0_ready}, 16'd0);

      // 1: single add, latency T -> T+2
      d1_rsp_ready = 1'b1;
      d1_req0_a = 8'd7; d1_req0_b = 8'd5; d1_req0_op = 3'b000; d1_req0_valid = 1'b1;
      #1;
      chk("t1_ready0", {15'd0, d1_req0_ready}, 16'd1);
      chk("t1_ready1", {15'd0, d1_req1_ready}, 16'd0);
      tick();
      d1_req0_valid = 1'b0;
      #1;
      chk("t1_exec_ena", {15'd0, d1_alu_ena}, 16'd1);
      chk("t1_exec_alu_a", {8'd0, d1_alu_a}, 16'd7);
      chk("t1_exec_alu_b", {8'd0, d1_alu_b}, 16'd5);
      chk("t1_exec_no_rsp", {15'd0, d1_rsp_valid}, 16'd0);
      chk("t1_exec_ready0", {15'd0, d1_req0_ready}, 16'd0);
      tick();
      chk("t1_rsp_valid", {15'd0, d1_rsp_valid}, 16'd1);
      chk("t1_rsp_ena_off", {15'd0, d1_alu_ena}, 16'd0);
      chk("t1_rsp_result", d1_rsp_result, 16'h000C);
      chk("t1_rsp_id", {15'd0, d1_rsp_id}, 16'd0);
      chk("t1_rsp_err", {15'd0, d1_rsp_err}, 16'd0);
      tick();
      chk("t1_done_valid", {15'd0, d1_rsp_valid}, 16'd0);
      chk("t1_done_busy", {15'd0, d1_busy}, 16'd0);

      // 2: simultaneous contest after reset, then alternation
      do_reset();
      d1_req0_a = 8'd200; d1_req0_b = 8'd3; d1_req0_op = 3'b010; d1_req0_valid = 1'b1;
      d1_req1_a = 8'd9;   d1_req1_b = 8'd4; d1_req1_op = 3'b001; d1_req1_valid = 1'b1;
      #1;
      chk("t2_c1_ready0", {15'd0, d1_req0_ready}, 16'd1);
      chk("t2_c1_ready1", {15'd0, d1_req1_ready}, 16'd0);
      tick();
      d1_req0_valid = 1'b0;
      wait_rsp("t2_mul", 1'b0, 16'h0258, 1'b0);
      chk("t2_c2_ready1", {15'd0, d1_req1_ready}, 16'd1);
      chk("t2_c2_ready0", {15'd0, d1_req0_ready}, 16'd0);
      tick();
      d1_req1_valid = 1'b0;
      wait_rsp("t2_sub", 1'b1, 16'h0005, 1'b0);
      d1_req0_a = 8'd1; d1_req0_b = 8'd2; d1_req0_op = 3'b000; d1_req0_valid = 1'b1;
      d1_req1_a = 8'd3; d1_req1_b = 8'd3; d1_req1_op = 3'b000; d1_req1_valid = 1'b1;
      #1;
      chk("t2_c3_ready0", {15'd0, d1_req0_ready}, 16'd1);
      chk("t2_c3_ready1", {15'd0, d1_req1_ready}, 16'd0);
      tick();
      d1_req0_valid = 1'b0;
      wait_rsp("t2_alt0", 1'b0, 16'h0003, 1'b0);
      chk("t2_c4_ready1", {15'd0, d1_req1_ready}, 16'd1);
      tick();
      d1_req1_valid = 1'b0;
      wait_rsp("t2_alt1", 1'b1, 16'h0006, 1'b0);

      // 3: divide by zero, then modulo
      d1_req1_a = 8'd10; d1_req1_b = 8'd0; d1_req1_op = 3'b011; d1_req1_valid = 1'b1;
      #1;
      chk("t3_div_ready1", {15'd0, d1_req1_ready}, 16'd1);
      tick();
      d1_req1_valid = 1'b0;
      wait_rsp("t3_div0", 1'b1, 16'h0000, 1'b1);
      d1_req1_a = 8'd10; d1_req1_b = 8'd3; d1_req1_op = 3'b100; d1_req1_valid = 1'b1;
      #1;
      tick();
      d1_req1_valid = 1'b0;
      wait_rsp("t3_mod", 1'b1, 16'h0001, 1'b0);

      // 4: consumer back-pressure for 5 cycles
      d1_rsp_ready = 1'b0;
      d1_req0_a = 8'd4; d1_req0_b = 8'd4; d1_req0_op = 3'b010; d1_req0_valid = 1'b1;
      #1;
      tick();
      d1_req0_valid = 1'b0;
      tick();
      d1_req0_valid = 1'b1;
      d1_req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", {15'd0, d1_rsp_valid}, 16'd1);
         chk("t4_hold_result", d1_rsp_result, 16'h0010);
         chk("t4_hold_id", {15'd0, d1_rsp_id}, 16'd0);
         chk("t4_hold_ready0", {15'd0, d1_req0_ready}, 16'd0);
         chk("t4_hold_ready1", {15'd0, d1_req1_ready}, 16'd0);
         tick();
      end
      d1_req0_valid = 1'b0;
      d1_req1_valid = 1'b0;
      d1_rsp_ready = 1'b1;
      #1;
      chk("t4_still_valid", {15'd0, d1_rsp_valid}, 16'd1);
      tick();
      chk("t4_released", {15'd0, d1_rsp_valid}, 16'd0);
      chk("t4_idle", {15'd0, d1_busy}, 16'd0);

      // 6: reset in EXEC abandons the op and restores req0 priority
      d1_req0_a = 8'd2; d1_req0_b = 8'd2; d1_req0_op = 3'b000; d1_req0_valid = 1'b1;
      #1;
      tick();
      d1_req0_valid = 1'b0;
      chk("t6_in_exec", {15'd0, d1_alu_ena}, 16'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_busy", {15'd0, d1_busy}, 16'd0);
      chk("t6_alu_ena", {15'd0, d1_alu_ena}, 16'd0);
      chk("t6_rsp_valid", {15'd0, d1_rsp_valid}, 16'd0);
      d1_req0_valid = 1'b1;
      d1_req1_valid = 1'b1;
      #1;
      chk("t6_ready0", {15'd0, d1_req0_ready}, 16'd1);
      chk("t6_ready1", {15'd0, d1_req1_ready}, 16'd0);
      d1_req0_valid = 1'b0;
      d1_req1_valid = 1'b0;
      tick();
      chk("t6_no_accept", {15'd0, d1_busy}, 16'd0);

      // 5: EXEC_CYCLES=3, equality op
      d3_req0_a = 8'd6; d3_req0_b = 8'd6; d3_req0_op = 3'b101; d3_req0_valid = 1'b1;
      #1;
      chk("t5_ready0", {15'd0, d3_req0_ready}, 16'd1);
      tick();
      d3_req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_ena_c%0d", i + 1), {15'd0, d3_alu_ena}, (i < 3) ? 16'd1 : 16'd0);
         chk($sformatf("t5_valid_c%0d", i + 1), {15'd0, d3_rsp_valid}, (i == 3) ? 16'd1 : 16'd0);
         if (i == 3) begin
            chk("t5_result", d3_rsp_result, 16'h0001);
            chk("t5_err", {15'd0, d3_rsp_err}, 16'd0);
         end
         tick();
      end
      chk("t5_done", {15'd0, d3_rsp_valid}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
